// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding an external combinational ALU; one command is issued at a time and
// its result is held with a valid/ready handshake until the consumer takes it.
module alu_cmd_issuer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [7:0]               cmd_a,
   input  logic [7:0]               cmd_b,
   input  logic [2:0]               cmd_sel,
   output logic [7:0]               alu_a,
   output logic [7:0]               alu_b,
   output logic [2:0]               alu_sel,
   input  logic [7:0]               alu_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [7:0]               res_data,
   output logic                     res_err,
   output logic [$clog2(DEPTH):0]   cmd_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

   state_e          state_q, state_d;
   logic [18:0]     mem_q [DEPTH];
   logic [18:0]     mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      alu_a_q, alu_a_d;
   logic [7:0]      alu_b_q, alu_b_d;
   logic [2:0]      alu_sel_q, alu_sel_d;
   logic [7:0]      res_data_q, res_data_d;
   logic            res_err_q, res_err_d;
   logic            push, pop;

   // Full blocks a push even when a pop happens in the same cycle.
   assign cmd_ready = (count_q != CW'(DEPTH));
   assign push      = cmd_valid & cmd_ready;

   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      pop        = 1'b0;
      case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = StDrive;
            end
         end
         StDrive: begin
            if (alu_sel_q == 3'b111 && alu_b_q == 8'h00) begin
               res_data_d = 8'hFF;
               res_err_d  = 1'b1;
            end else begin
               res_data_d = alu_out;
               res_err_d  = 1'b0;
            end
            state_d = StResp;
         end
         StResp: begin
            if (res_ready) begin
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = StDrive;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (pop) begin
         {alu_a_d, alu_b_d, alu_sel_d} = mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = {cmd_a, cmd_b, cmd_sel};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         alu_a_q    <= 8'h00;
         alu_b_q    <= 8'h00;
         alu_sel_q  <= 3'b000;
         res_data_q <= 8'h00;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         res_data_q <= res_data_d;
         res_err_q  <= res_err_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;
   assign res_valid = (state_q == StResp);
   assign cmd_count = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed scenarios plus randomized traffic checked against an
// in-order queue of expected results, with an ALU model standing in for the external ALU.
module tb_alu_cmd_issuer;

   localparam int unsigned DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [7:0]             cmd_a, cmd_b;
   logic [2:0]             cmd_sel;
   logic [7:0]             alu_a, alu_b;
   logic [2:0]             alu_sel;
   logic [7:0]             alu_out;
   logic                   res_valid;
   logic                   res_ready;
   logic [7:0]             res_data;
   logic                   res_err;
   logic [$clog2(DEPTH):0] cmd_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [8:0] sb_q [$];

   alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_sel   (cmd_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .cmd_count (cmd_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] sel);
      case (sel)
         3'b000:  return 8'(a - b);
         3'b001:  return ~(a ^ b);
         3'b010:  return a ^ b;
         3'b011:  return a >> 1;
         3'b100:  return 8'(a << 1);
         3'b101:  return a | b;
         3'b110:  return a & b;
         default: return (b == 8'h00) ? 8'h00 : 8'(a / b);
      endcase
   endfunction

   // Expected {err, data} for a command as seen by the consumer.
   function automatic logic [8:0] exp_res(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] sel);
      if (sel == 3'b111 && b == 8'h00) return 9'h1FF;
      return {1'b0, alu_model(a, b, sel)};
   endfunction

   always_comb alu_out = alu_model(alu_a, alu_b, alu_sel);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
      int n = 0;
      cmd_a     = a;
      cmd_b     = b;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("push_timeout", 32'(cmd_ready), 32'(1));
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic [8:0] exp);
      int n = 0;
      while (!res_valid && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check({tag, "_timeout"}, 32'(res_valid), 32'(1));
      else         check(tag, 32'({res_err, res_data}), 32'(exp));
      tick();
   endtask

   // Scoreboard: inputs settle 1 time unit after the rising edge, so the falling edge sees
   // exactly the handshakes that the next rising edge will perform.
   always @(negedge clk) begin
      int sz;
      int occ;
      if (rst) begin
         sb_q.delete();
      end else begin
         sz  = sb_q.size();
         occ = int'(cmd_count);
         check("ready_inv", 32'(cmd_ready), 32'(occ != int'(DEPTH)));
         // At most one accepted command may be outside the FIFO, and a shown result is it.
         check("occupancy", 32'((sz >= occ) && (sz - occ <= 1) && (!res_valid || sz - occ == 1)),
               32'(1));
         if (res_valid && res_ready) begin
            if (sz == 0) check("sb_empty", 32'(1), 32'(0));
            else         check("sb_data", 32'({res_err, res_data}), 32'(sb_q.pop_front()));
         end
         if (cmd_valid && cmd_ready) sb_q.push_back(exp_res(cmd_a, cmd_b, cmd_sel));
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int acc;
      int n;
      logic seen;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_sel   = 3'b000;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_valid", 32'(res_valid), 32'(0));
      check("rst_count", 32'(cmd_count), 32'(0));
      check("rst_ready", 32'(cmd_ready), 32'(1));
      check("rst_data",  32'(res_data),  32'(8'h00));
      check("rst_err",   32'(res_err),   32'(0));
      check("rst_alu",   32'({alu_a, alu_b, alu_sel}), 32'(0));

      // Latency: accept at edge N, result visible after edge N+2.
      res_ready = 1'b1;
      cmd_a = 8'h10; cmd_b = 8'h03; cmd_sel = 3'b000; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("lat_n0", 32'(res_valid), 32'(0));
      tick();
      check("lat_n1", 32'(res_valid), 32'(0));
      tick();
      check("lat_n2", 32'(res_valid), 32'(1));
      check("lat_data", 32'(res_data), 32'(8'h0D));
      check("lat_err", 32'(res_err), 32'(0));
      tick();

      res_ready = 1'b0;
      push_one(8'h03, 8'h05, 3'b000);
      push_one(8'h81, 8'h00, 3'b100);
      push_one(8'h64, 8'h07, 3'b111);
      res_ready = 1'b1;
      expect_res("ord_0", 9'h0FE);
      expect_res("ord_1", 9'h002);
      expect_res("ord_2", 9'h00E);

      res_ready = 1'b0;
      push_one(8'h64, 8'h00, 3'b111);
      push_one(8'h0F, 8'hF0, 3'b101);
      res_ready = 1'b1;
      expect_res("div0", 9'h1FF);
      expect_res("or_ff", 9'h0FF);
      repeat (2) tick();

      // Fill while the consumer stalls; the sixth command must be held off.
      res_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_a = 8'(23 * i + 9); cmd_b = 8'(i + 1); cmd_sel = 3'(i + 2); cmd_valid = 1'b1;
         if (cmd_ready) acc++;
         tick();
      end
      tick();
      check("full_acc", 32'(acc), 32'(5));
      check("full_count", 32'(cmd_count), 32'(4));
      check("full_ready", 32'(cmd_ready), 32'(0));
      check("full_head", 32'({res_valid, res_err, res_data}),
            32'({1'b1, exp_res(8'd9, 8'd1, 3'd2)}));
      res_ready = 1'b1;
      check("popfull_ready", 32'(cmd_ready), 32'(0));
      tick();
      check("popfull_count", 32'(cmd_count), 32'(3));
      check("popfull_ready1", 32'(cmd_ready), 32'(1));
      tick();
      cmd_valid = 1'b0;
      for (int i = 1; i < 6; i++) begin
         expect_res($sformatf("drain_%0d", i), exp_res(8'(23 * i + 9), 8'(i + 1), 3'(i + 2)));
      end
      repeat (2) tick();

      // Reset while a result is pending and three commands are queued.
      res_ready = 1'b0;
      push_one(8'h11, 8'h22, 3'b010);
      push_one(8'h33, 8'h44, 3'b110);
      push_one(8'h55, 8'h66, 3'b001);
      push_one(8'h77, 8'h02, 3'b111);
      check("pre_rst_valid", 32'(res_valid), 32'(1));
      check("pre_rst_count", 32'(cmd_count), 32'(3));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 32'(res_valid), 32'(0));
      check("mid_rst_count", 32'(cmd_count), 32'(0));
      check("mid_rst_ready", 32'(cmd_ready), 32'(1));
      res_ready = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (res_valid) seen = 1'b1;
      end
      check("stale_result", 32'(seen), 32'(0));

      for (int i = 0; i < 1500; i++) begin
         cmd_valid = ($urandom_range(0, 9) < 6);
         cmd_a     = 8'($urandom);
         cmd_b     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         cmd_sel   = 3'($urandom);
         res_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
         rst       = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
         tick();
      end
      rst       = 1'b0;
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("rand_drain", 32'(sb_q.size()), 32'(0));
      repeat (3) tick();
      check("end_idle", 32'({res_valid, cmd_count}), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
- REQ-001 Parameter: DEPTH, 4, command FIFO entries; power of two, range 2..16.
- REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 Port: rst  input  1  reset; synchronous, active-high.
- REQ-004 Port: cmd_valid  input  1  a command is offered on cmd_a/cmd_b/cmd_sel.
- REQ-005 Port: cmd_ready  output  1  FIFO can accept a command; equals not-full.
- REQ-006 Port: cmd_a  input  8  operand A.
- REQ-007 Port: cmd_b  input  8  operand B.
- REQ-008 Port: cmd_sel  input  3  opcode; 000 sub, 001 xnor, 010 xor, 011 A>>1, 100 A<<1, 101 or, 110 and, 111 div.
- REQ-009 Port: alu_a  output  8  registered operand A to the external combinational ALU.
- REQ-010 Port: alu_b  output  8  registered operand B to the ALU.
- REQ-011 Port: alu_sel  output  3  registered opcode to the ALU.
- REQ-012 Port: alu_out  input  8  ALU result; combinational from alu_a/alu_b/alu_sel.
- REQ-013 Port: res_valid  output  1  res_data/res_err hold a result.
- REQ-014 Port: res_ready  input  1  the consumer accepts the result.
- REQ-015 Port: res_data  output  8  captured result.
- REQ-016 Port: res_err  output  1  the result came from divide-by-zero.
- REQ-017 Port: cmd_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
- REQ-018 A command SHALL be pushed when cmd_valid and cmd_ready are both high at a rising edge. {a,b,sel} is stored in FIFO order.
- REQ-019 cmd_ready SHALL be low whenever cmd_count equals DEPTH, even in a cycle where a pop occurs. No push is accepted when full.
- REQ-020 If a push and a pop occur in the same cycle, cmd_count SHALL remain unchanged and both operations SHALL take effect.
- REQ-021 FIFO read/write pointers SHALL wrap modulo DEPTH.
- REQ-022 The FSM SHALL have three states: IDLE, DRIVE, RESP.
- REQ-023 IDLE with cmd_count > 0: pop the head and load alu_a/alu_b/alu_sel from it, then go to DRIVE. IDLE with an empty FIFO: remain in IDLE.
- REQ-024 DRIVE:
  - capture res_data from alu_out and set res_err = 0;
  - exception: if alu_sel = 111 and alu_b = 0, set res_data = 8'hFF and res_err = 1 instead;
  - then go to RESP.
- REQ-025 RESP: res_valid SHALL be 1, and res_data/res_err SHALL be held stable until accepted.
- REQ-026 RESP with res_ready = 1 and cmd_count > 0: pop, load operands, go to DRIVE (back-to-back issue).
- REQ-027 RESP with res_ready = 1 and an empty FIFO: go to IDLE.
- REQ-028 RESP with res_ready = 0: remain in RESP.
- REQ-029 res_valid SHALL be 0 in IDLE and DRIVE.
- REQ-030 alu_a/alu_b/alu_sel SHALL change only on a pop and SHALL be stable throughout DRIVE.
- REQ-031 Latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE SHALL produce res_valid = 1 after edge N+2.
- REQ-032 Sustained throughput with res_ready held high SHALL be one result per 2 cycles.
- REQ-033 Arithmetic SHALL be 8-bit modulo. Sub underflow wraps, and shifts discard the bit shifted out; the block does not modify ALU results except the divide-by-zero case in REQ-024.
- REQ-034 Results SHALL be delivered in command acceptance order.

Reset
- REQ-035 On rst = 1 at a rising edge, the block SHALL:
  - go to IDLE;
  - empty the FIFO (cmd_count = 0, pointers = 0);
  - set res_valid = 0, res_data = 8'h00, res_err = 0;
  - set alu_a = 8'h00, alu_b = 8'h00, alu_sel = 3'b000.
- REQ-036 Reset SHALL take priority over push and pop in the same cycle. Any in-flight or queued command SHALL be discarded without producing a result.
- REQ-037 cmd_ready SHALL be 1 in the first cycle after reset is released.

Verification
- REQ-038 Push {A=8'h10, B=8'h03, sel=000} with res_ready = 1: res_valid rises 2 edges after acceptance, res_data = 8'h0D, res_err = 0.
- REQ-039 Push {8'h03, 8'h05, 000}, then {8'h81, 8'h00, 100}, then {8'h64, 8'h07, 111}: results are 8'hFE, 8'h02, 8'h0E, in that order.
- REQ-040 Push {8'h64, 8'h00, 111}: res_data = 8'hFF, res_err = 1. A following {8'h0F, 8'hF0, 101} gives res_data = 8'hFF, res_err = 0.
- REQ-041 Hold res_ready = 0 and offer 6 back-to-back commands: exactly 5 are accepted (1 in RESP, 4 queued), cmd_count = 4, cmd_ready = 0, and the 6th is held. Releasing res_ready drains 5 results in order.
- REQ-042 Assert rst for one cycle while in RESP with 3 commands queued: next cycle res_valid = 0, cmd_count = 0, cmd_ready = 1, and no stale result appears afterward.
- REQ-043 With cmd_count = 4 and in RESP, assert res_ready and cmd_valid together: the pop occurs, the push is refused that cycle (cmd_ready = 0), and cmd_count becomes 3.
